// File: rtl/uart_mem_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to an Avalon-MM RAM slave.
// Optional running byte checksum output enabled by defining UART_MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int DEPTH  = 2500,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              flush,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              wrapped,
  output logic [15:0]       words_written
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [3:0]        en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              accept;

  // A start pulse steals the cycle so the byte presented alongside it is refused.
  assign in_ready = ~reset & (state_q != WRITE) & ~start;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q     <= 2'd0;
      shadow_q   <= 32'd0;
      en_q       <= 4'd0;
      addr_q     <= '0;
      wrapped_q  <= 1'b0;
      count_q    <= 16'd0;
      checksum_q <= 32'd0;
    end else begin
      lane_q     <= lane_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      wrapped_q  <= wrapped_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    addr_d     = addr_q;
    wrapped_d  = wrapped_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    if (state_q == WRITE) begin
      count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      if (addr_q == LAST_ADDR) wrapped_d = 1'b1;
      lane_d   = 2'd0;
      shadow_d = 32'd0;
      en_d     = 4'd0;
      state_d  = IDLE;
    end else if (accept) begin
      shadow_d[8*lane_q +: 8] = in_data;
      en_d[lane_q]            = 1'b1;
      lane_d                  = lane_q + 2'd1;
      checksum_d              = checksum_q + {24'd0, in_data};
      state_d                 = (lane_q == 2'd3 || flush) ? WRITE : FILL;
    end else if (flush && state_q == FILL) begin
      state_d = WRITE;
    end
    // A write already on the bus still counts, but start then owns the address.
    if (start) begin
      addr_d     = (start_addr > LAST_ADDR) ? '0 : start_addr;
      lane_d     = 2'd0;
      shadow_d   = 32'd0;
      en_d       = 4'd0;
      wrapped_d  = 1'b0;
      checksum_d = 32'd0;
      state_d    = IDLE;
    end
  end

  always_comb begin
    chipselect = 1'b0;
    write      = 1'b0;
    byteenable = 4'd0;
    writedata  = 32'd0;
    if (state_q == WRITE) begin
      chipselect = 1'b1;
      write      = 1'b1;
      byteenable = en_q;
      writedata  = shadow_q;
    end
  end

  assign address       = addr_q;
  assign busy          = (state_q != IDLE);
  assign wrapped       = wrapped_q;
  assign words_written = count_q;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed, table-driven bench for uart_mem_loader plus hand sequences for streaming and reset.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic [11:0] start_addr;
  logic        flush;
  logic [11:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        busy;
  logic        wrapped;
  logic [15:0] words_written;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        start;
    logic [11:0] saddr;
    logic        flush;
    logic        e_write;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_ready;
    logic        e_busy;
    logic        e_wrapped;
    logic [15:0] e_words;
  } vec_t;

  vec_t vecs[$];

  uart_mem_loader #(.DEPTH(2500), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .start_addr(start_addr), .flush(flush), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write), .writedata(writedata),
    .busy(busy), .wrapped(wrapped), .words_written(words_written)
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic v, input logic [7:0] d, input logic s, input logic [11:0] sa,
                         input logic f, input logic ew, input logic [11:0] ea, input logic [31:0] ed,
                         input logic [3:0] eb, input logic er, input logic ebz, input logic ewr,
                         input logic [15:0] ewd);
    vec_t x;
    x.valid = v; x.data = d; x.start = s; x.saddr = sa; x.flush = f;
    x.e_write = ew; x.e_addr = ea; x.e_data = ed; x.e_be = eb; x.e_ready = er;
    x.e_busy = ebz; x.e_wrapped = ewr; x.e_words = ewd;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t x);
    @(negedge clk);
    in_valid = x.valid; in_data = x.data; start = x.start; start_addr = x.saddr; flush = x.flush;
  endtask

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t x);
    logic ok;
    #1;
    ok = (write === x.e_write) && (chipselect === x.e_write) && (address === x.e_addr) &&
         (in_ready === x.e_ready) && (busy === x.e_busy) && (wrapped === x.e_wrapped) &&
         (words_written === x.e_words) && (byteenable === (x.e_write ? x.e_be : 4'd0)) &&
         (!x.e_write || writedata === x.e_data);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: got wr=%b cs=%b addr=%h data=%h be=%h rdy=%b busy=%b wrap=%b words=%0d, wanted wr=%b addr=%h data=%h be=%h rdy=%b busy=%b wrap=%b words=%0d",
               idx, write, chipselect, address, writedata, byteenable, in_ready, busy, wrapped,
               words_written, x.e_write, x.e_addr, x.e_data, x.e_be, x.e_ready, x.e_busy,
               x.e_wrapped, x.e_words);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'd0; start = 1'b0; start_addr = 12'd0; flush = 1'b0;
  endtask

  initial begin
    // Columns: valid data start saddr flush | write addr wdata be ready busy wrapped words
    add_vec(1, 8'h99, 1, 12'h010, 0,  0, 12'h000, 32'h0,        4'h0, 0, 0, 0, 16'd0);
    add_vec(1, 8'h11, 0, 12'h000, 0,  0, 12'h010, 32'h0,        4'h0, 1, 0, 0, 16'd0);
    add_vec(1, 8'h22, 0, 12'h000, 0,  0, 12'h010, 32'h0,        4'h0, 1, 1, 0, 16'd0);
    add_vec(1, 8'h33, 0, 12'h000, 0,  0, 12'h010, 32'h0,        4'h0, 1, 1, 0, 16'd0);
    add_vec(1, 8'h44, 0, 12'h000, 0,  0, 12'h010, 32'h0,        4'h0, 1, 1, 0, 16'd0);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h010, 32'h44332211, 4'hF, 0, 1, 0, 16'd0);
    add_vec(0, 8'h00, 0, 12'h000, 0,  0, 12'h011, 32'h0,        4'h0, 1, 0, 0, 16'd1);
    add_vec(1, 8'hAA, 0, 12'h000, 0,  0, 12'h011, 32'h0,        4'h0, 1, 0, 0, 16'd1);
    add_vec(1, 8'hBB, 0, 12'h000, 0,  0, 12'h011, 32'h0,        4'h0, 1, 1, 0, 16'd1);
    add_vec(0, 8'h00, 0, 12'h000, 1,  0, 12'h011, 32'h0,        4'h0, 1, 1, 0, 16'd1);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h011, 32'h0000BBAA, 4'h3, 0, 1, 0, 16'd1);
    add_vec(0, 8'h00, 0, 12'h000, 1,  0, 12'h012, 32'h0,        4'h0, 1, 0, 0, 16'd2);
    add_vec(0, 8'h00, 0, 12'h000, 0,  0, 12'h012, 32'h0,        4'h0, 1, 0, 0, 16'd2);
    add_vec(0, 8'h00, 1, 12'h9C3, 0,  0, 12'h012, 32'h0,        4'h0, 0, 0, 0, 16'd2);
    add_vec(1, 8'h01, 0, 12'h000, 0,  0, 12'h9C3, 32'h0,        4'h0, 1, 0, 0, 16'd2);
    add_vec(1, 8'h02, 0, 12'h000, 0,  0, 12'h9C3, 32'h0,        4'h0, 1, 1, 0, 16'd2);
    add_vec(1, 8'h03, 0, 12'h000, 0,  0, 12'h9C3, 32'h0,        4'h0, 1, 1, 0, 16'd2);
    add_vec(1, 8'h04, 0, 12'h000, 0,  0, 12'h9C3, 32'h0,        4'h0, 1, 1, 0, 16'd2);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h9C3, 32'h04030201, 4'hF, 0, 1, 0, 16'd2);
    add_vec(1, 8'h05, 0, 12'h000, 0,  0, 12'h000, 32'h0,        4'h0, 1, 0, 1, 16'd3);
    add_vec(1, 8'h06, 0, 12'h000, 0,  0, 12'h000, 32'h0,        4'h0, 1, 1, 1, 16'd3);
    add_vec(1, 8'h07, 0, 12'h000, 0,  0, 12'h000, 32'h0,        4'h0, 1, 1, 1, 16'd3);
    add_vec(1, 8'h08, 0, 12'h000, 0,  0, 12'h000, 32'h0,        4'h0, 1, 1, 1, 16'd3);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h000, 32'h08070605, 4'hF, 0, 1, 1, 16'd3);
    add_vec(0, 8'h00, 1, 12'h005, 0,  0, 12'h001, 32'h0,        4'h0, 0, 0, 1, 16'd4);
    add_vec(1, 8'hA1, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 0, 0, 16'd4);
    add_vec(1, 8'hA2, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 1, 0, 16'd4);
    add_vec(1, 8'hA3, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 1, 0, 16'd4);
    add_vec(1, 8'hEE, 1, 12'h005, 0,  0, 12'h005, 32'h0,        4'h0, 0, 1, 0, 16'd4);
    add_vec(1, 8'hB1, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 0, 0, 16'd4);
    add_vec(1, 8'hB2, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 1, 0, 16'd4);
    add_vec(1, 8'hB3, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 1, 0, 16'd4);
    add_vec(1, 8'hB4, 0, 12'h000, 0,  0, 12'h005, 32'h0,        4'h0, 1, 1, 0, 16'd4);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h005, 32'hB4B3B2B1, 4'hF, 0, 1, 0, 16'd4);
    add_vec(0, 8'h00, 0, 12'h000, 0,  0, 12'h006, 32'h0,        4'h0, 1, 0, 0, 16'd5);
    add_vec(0, 8'h00, 1, 12'hFFF, 0,  0, 12'h006, 32'h0,        4'h0, 0, 0, 0, 16'd5);
    add_vec(0, 8'h00, 0, 12'h000, 0,  0, 12'h000, 32'h0,        4'h0, 1, 0, 0, 16'd5);
    add_vec(1, 8'hC1, 0, 12'h000, 1,  0, 12'h000, 32'h0,        4'h0, 1, 0, 0, 16'd5);
    add_vec(0, 8'h00, 0, 12'h000, 0,  1, 12'h000, 32'h000000C1, 4'h1, 0, 1, 0, 16'd5);
    add_vec(0, 8'h00, 0, 12'h000, 0,  0, 12'h001, 32'h0,        4'h0, 1, 0, 0, 16'd6);

    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; start = 1'b0; start_addr = 12'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", (in_ready === 1'b0) && (write === 1'b0) && (chipselect === 1'b0) &&
          (byteenable === 4'd0) && (busy === 1'b0) && (wrapped === 1'b0) &&
          (words_written === 16'd0) && (address === 12'd0),
          {in_ready, write, busy, wrapped, address, words_written[11:0]}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Continuous stream of 12 bytes from address 0: in_ready must drop only in WRITE cycles.
    begin
      int accepted = 0, writes = 0, bad_ready = 0, cycles = 0;
      logic [7:0] next_byte = 8'h30;
      logic [31:0] exp_word;
      @(negedge clk);
      in_valid = 1'b0; start = 1'b1; start_addr = 12'd0; flush = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (writes < 3 && cycles < 100) begin
        in_valid = (accepted < 12);
        in_data = next_byte;
        #1;
        if (write) begin
          exp_word = {next_byte - 8'd1, next_byte - 8'd2, next_byte - 8'd3, next_byte - 8'd4};
          check($sformatf("stream_write%0d", writes),
                (address === 12'(writes)) && (writedata === exp_word) && (byteenable === 4'hF),
                writedata, exp_word);
          writes++;
        end
        if (in_ready === write) bad_ready++;
        if (in_valid && in_ready) begin
          accepted++;
          next_byte = next_byte + 8'd1;
        end
        cycles++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("stream_writes", writes == 3, writes, 3);
      check("stream_accepted", accepted == 12, accepted, 12);
      check("stream_ready_pattern", bad_ready == 0, bad_ready, 0);
      #1;
      check("stream_words", words_written === 16'd9, words_written, 9);
    end

    // Reset landing in a WRITE cycle must drop the strobe without waiting for a clock edge.
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + b);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("pre_reset_write", write === 1'b1, write, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_write", (write === 1'b0) && (chipselect === 1'b0) && (busy === 1'b0) &&
          (words_written === 16'd0), {write, chipselect, busy, words_written[11:0]}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] cs_bytes [3];
      cs_bytes[0] = 8'hFF; cs_bytes[1] = 8'hFF; cs_bytes[2] = 8'h01;
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        in_valid = 1'b1; in_data = cs_bytes[b];
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("checksum_sum", checksum === 32'h000001FF, checksum, 32'h000001FF);
      @(negedge clk);
      start = 1'b1; start_addr = 12'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("checksum_clear", checksum === 32'h0, checksum, 32'h0);
    end
`endif

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
